// File: rtl/apb_slave.sv
// ---------------------------------------------------------------------------
// apb_slave
//   APB completer with a 16-entry register file and a fixed number of wait
//   states per transfer. Entries 0..14 are read/write with byte strobes;
//   entry 15 is a read-only identification word (0xA5B0_0001).
//   Misaligned addresses, addresses at or above 0x40, and writes to the ID
//   word complete with PSLVERR=1 and have no side effect.
//
// Ports
//   PCLK     in   rising-edge clock
//   PRESETn  in   asynchronous active-low reset
//   PSEL     in   slave select
//   PENABLE  in   access phase
//   PWRITE   in   1 = write, 0 = read
//   PADDR    in   byte address [ADDWIDTH-1:0]
//   PWDATA   in   write data [DATAWIDTH-1:0]
//   PSTRB    in   write byte-lane enables [DATAWIDTH/8-1:0]
//   PREADY   out  transfer complete (high for exactly one cycle)
//   PRDATA   out  read data, zero outside a successful read response
//   PSLVERR  out  transfer error, qualified by PREADY
// ---------------------------------------------------------------------------
module apb_slave #(
  parameter int ADDWIDTH   = 8,
  parameter int DATAWIDTH  = 32,
  parameter int WAITCYCLES = 2
) (
  input  logic                   PCLK,
  input  logic                   PRESETn,
  input  logic                   PSEL,
  input  logic                   PENABLE,
  input  logic                   PWRITE,
  input  logic [ADDWIDTH-1:0]    PADDR,
  input  logic [DATAWIDTH-1:0]   PWDATA,
  input  logic [DATAWIDTH/8-1:0] PSTRB,
  output logic                   PREADY,
  output logic [DATAWIDTH-1:0]   PRDATA,
  output logic                   PSLVERR
);

  localparam int                   NLANES    = DATAWIDTH / 8;
  localparam logic [DATAWIDTH-1:0] ID_VALUE  = DATAWIDTH'(32'hA5B0_0001);
  localparam logic [3:0]           WAIT_INIT = 4'(WAITCYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state_reg;
  logic [3:0]            cnt_reg;
  logic [ADDWIDTH-1:0]   addr_reg;
  logic                  write_reg;
  logic [DATAWIDTH-1:0]  wdata_reg;
  logic [NLANES-1:0]     strb_reg;
  logic                  err_reg;
  logic                  pready_reg;
  logic                  pslverr_reg;
  logic [DATAWIDTH-1:0]  prdata_reg;

  logic                  setup_cycle;
  logic                  high_addr;
  logic                  setup_err;
  logic [3:0]            cur_idx;
  logic                  cur_write;
  logic                  cur_err;
  logic [DATAWIDTH-1:0]  rd_word;
  logic                  wr_commit;

  assign setup_cycle = (state_reg == IDLE) && PSEL && !PENABLE;

  // Any address bit at or above bit 6 set means the request is beyond 0x3F.
  generate
    if (ADDWIDTH > 6) begin : g_hi
      assign high_addr = |PADDR[ADDWIDTH-1:6];
    end else begin : g_nohi
      assign high_addr = 1'b0;
    end
  endgenerate

  assign setup_err = (PADDR[1:0] != 2'b00) || high_addr ||
                     (PWRITE && (PADDR[5:2] == 4'hF));

  // With zero wait states the response is built on the setup edge itself,
  // so the read path must look at the live bus rather than the latches.
  assign cur_idx   = setup_cycle ? PADDR[5:2] : addr_reg[5:2];
  assign cur_write = setup_cycle ? PWRITE     : write_reg;
  assign cur_err   = setup_cycle ? setup_err  : err_reg;

  assign wr_commit = (state_reg == RESP) && PSEL && PENABLE && write_reg && !err_reg;

  // One byte-wide storage array per lane so each strobe owns its own state.
  // Entry 15 is never written; its read is replaced by the ID word.
  genvar gi;
  generate
    for (gi = 0; gi < NLANES; gi++) begin : g_lane
      logic [7:0] mem_reg [0:15];

      always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
          for (int i = 0; i < 16; i++) begin
            mem_reg[i] <= 8'h00;
          end
        end else if (wr_commit && strb_reg[gi]) begin
          mem_reg[addr_reg[5:2]] <= wdata_reg[gi*8 +: 8];
        end
      end

      assign rd_word[gi*8 +: 8] = (cur_idx == 4'hF) ? ID_VALUE[gi*8 +: 8]
                                                    : mem_reg[cur_idx];
    end
  endgenerate

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_reg   <= IDLE;
      cnt_reg     <= 4'd0;
      addr_reg    <= '0;
      write_reg   <= 1'b0;
      wdata_reg   <= '0;
      strb_reg    <= '0;
      err_reg     <= 1'b0;
      pready_reg  <= 1'b0;
      pslverr_reg <= 1'b0;
      prdata_reg  <= '0;
    end else begin
      // Response outputs live for exactly the one RESP cycle.
      pready_reg  <= 1'b0;
      pslverr_reg <= 1'b0;
      prdata_reg  <= '0;
      case (state_reg)
        IDLE: begin
          // PENABLE without a preceding setup cycle is ignored here.
          if (setup_cycle) begin
            addr_reg  <= PADDR;
            write_reg <= PWRITE;
            wdata_reg <= PWDATA;
            strb_reg  <= PSTRB;
            err_reg   <= setup_err;
            if (WAITCYCLES == 0) begin
              state_reg   <= RESP;
              pready_reg  <= 1'b1;
              pslverr_reg <= cur_err;
              prdata_reg  <= (!cur_write && !cur_err) ? rd_word : '0;
            end else begin
              state_reg <= WAIT;
              cnt_reg   <= WAIT_INIT;
            end
          end
        end
        WAIT: begin
          if (!PSEL) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
          end else if (cnt_reg == 4'd1) begin
            state_reg   <= RESP;
            cnt_reg     <= 4'd0;
            pready_reg  <= 1'b1;
            pslverr_reg <= cur_err;
            prdata_reg  <= (!cur_write && !cur_err) ? rd_word : '0;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        RESP: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign PREADY  = pready_reg;
  assign PSLVERR = pslverr_reg;
  assign PRDATA  = prdata_reg;

endmodule

// File: tb/tb_apb_slave.sv
// ---------------------------------------------------------------------------
// tb_apb_slave
//   Two slaves share one APB bus (separate PSEL): dut0 with two wait states,
//   dut1 with none. The driver issues transfers and pushes the reference
//   model's expected response into a per-slave queue; a monitor pops and
//   compares whenever a slave raises PREADY, and checks that outputs stay
//   zero at all other times.
// ---------------------------------------------------------------------------
module tb_apb_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        psel0 = 1'b0, psel1 = 1'b0;
  logic        penable = 1'b0, pwrite = 1'b0;
  logic [7:0]  paddr = '0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = '0;
  logic        pready0, pready1, pslverr0, pslverr1;
  logic [31:0] prdata0, prdata1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  apb_slave #(.ADDWIDTH(8), .DATAWIDTH(32), .WAITCYCLES(2)) dut0 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel0), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PREADY(pready0), .PRDATA(prdata0), .PSLVERR(pslverr0));

  apb_slave #(.ADDWIDTH(8), .DATAWIDTH(32), .WAITCYCLES(0)) dut1 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel1), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PREADY(pready1), .PRDATA(prdata1), .PSLVERR(pslverr1));

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          waits;
    bit          wr;
    logic [7:0]  addr;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] model_mem [2][16];

  function automatic void model_clear();
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < 16; i++)
        model_mem[w][i] = 32'h0;
  endfunction

  function automatic exp_t model_xfer(int w, bit wr, logic [7:0] a,
                                      logic [31:0] d, logic [3:0] s);
    exp_t e;
    int   idx;
    idx     = int'(a) / 4 % 16;
    e.err   = (a % 4 != 0) || (a >= 8'h40) || (wr && idx == 15);
    e.waits = (w == 0) ? 2 : 0;
    e.wr    = wr;
    e.addr  = a;
    e.rdata = 32'h0;
    if (!e.err) begin
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (s[b]) model_mem[w][idx][8*b +: 8] = d[8*b +: 8];
      end else begin
        e.rdata = (idx == 15) ? 32'hA5B0_0001 : model_mem[w][idx];
      end
    end
    return e;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  int acc_cnt [2];

  always @(negedge clk) begin
    for (int w = 0; w < 2; w++) begin
      logic        sel, rdy, err;
      logic [31:0] rd;
      exp_t        e;
      bit          have;
      sel = (w == 0) ? psel0 : psel1;
      rdy = (w == 0) ? pready0 : pready1;
      err = (w == 0) ? pslverr0 : pslverr1;
      rd  = (w == 0) ? prdata0 : prdata1;
      if (sel && !penable) acc_cnt[w] = 0;
      else if (sel && penable && !rdy) acc_cnt[w]++;
      vectors++;
      if (rdy) begin
        have = (w == 0) ? (q0.size() > 0) : (q1.size() > 0);
        if (!have) begin
          miscompares++;
          $display("FAIL unexpected_pready dut%0d: PREADY=1 but no transfer expected a response", w);
        end else begin
          e = (w == 0) ? q0.pop_front() : q1.pop_front();
          $display("dut%0d %s addr=%02h rdata=%08h err=%0d waits=%0d", w,
                   e.wr ? "WR" : "RD", e.addr, rd, err, acc_cnt[w]);
          if (rd !== e.rdata || err !== e.err || acc_cnt[w] != e.waits) begin
            miscompares++;
            $display("FAIL response dut%0d addr=%02h: got rdata=%08h err=%0d waits=%0d, want rdata=%08h err=%0d waits=%0d",
                     w, e.addr, rd, err, acc_cnt[w], e.rdata, e.err, e.waits);
          end
        end
      end else if (rd !== 32'h0 || err !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_outputs dut%0d: got rdata=%08h err=%0d, want 0/0", w, rd, err);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic set_sel(input int w, input logic v);
    if (w == 0) psel0 = v; else psel1 = v;
  endtask

  function automatic logic rdy_of(input int w);
    return (w == 0) ? pready0 : pready1;
  endfunction

  task automatic check_cleared(input string name);
    vectors++;
    if (pready0 !== 1'b0 || prdata0 !== 32'h0 || pslverr0 !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: got pready=%0d rdata=%08h err=%0d, want all 0",
               name, pready0, prdata0, pslverr0);
    end
  endtask

  // mode 0: normal, 1: drop PSEL during WAIT, 2: reset pulse during WAIT,
  // 3: normal response then reset pulse while PREADY is high
  task automatic xfer(input int w, input bit wr, input logic [7:0] a,
                      input logic [31:0] d, input logic [3:0] s, input int mode);
    bit got;
    set_sel(w, 1'b1);
    penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
    if (mode == 0 || mode == 3) begin
      if (w == 0) q0.push_back(model_xfer(w, wr, a, d, s));
      else        q1.push_back(model_xfer(w, wr, a, d, s));
    end
    @(posedge clk); #1;
    penable = 1'b1;
    if (mode == 1) begin
      @(posedge clk); #1;
      set_sel(w, 1'b0); penable = 1'b0;
      return;
    end
    if (mode == 2) begin
      @(negedge clk); #1;
      rst_n = 1'b0; #1;
      check_cleared("reset_in_wait");
      #2 rst_n = 1'b1;
      model_clear();
      repeat (2) begin @(posedge clk); #1; end
      set_sel(w, 1'b0); penable = 1'b0;
      return;
    end
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rdy_of(w)) begin got = 1; break; end
    end
    if (!got) begin
      vectors++; miscompares++;
      $display("FAIL timeout dut%0d addr=%02h: PREADY never rose within 20 cycles", w, a);
    end
    if (mode == 3) begin
      #1 rst_n = 1'b0; #1;
      check_cleared("reset_in_resp");
      #2 rst_n = 1'b1;
      model_clear();
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic logic [7:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 8)       return 8'($urandom_range(0, 15) * 4);
    else if (r == 8) return 8'($urandom_range(0, 63) | 1);
    else             return 8'($urandom_range(64, 255));
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    model_clear();
    #1;
    check_cleared("reset_state");
    #21 rst_n = 1'b1;
    @(posedge clk); #1;
    idle(1);

    // full-word write then read back
    xfer(0, 1, 8'h04, 32'h1234_5678, 4'hF, 0); idle(1);
    xfer(0, 0, 8'h04, 32'h0, 4'h0, 0);          idle(1);
    // partial strobes, back-to-back write/read
    xfer(0, 1, 8'h08, 32'hFFFF_FFFF, 4'h5, 0);
    xfer(0, 0, 8'h08, 32'h0, 4'h0, 0);          idle(1);
    // ID word, illegal write to it, out-of-range misaligned read
    xfer(0, 0, 8'h3C, 32'h0, 4'h0, 0);
    xfer(0, 1, 8'h3C, 32'hFFFF_FFFF, 4'hF, 0);
    xfer(0, 0, 8'h3C, 32'h0, 4'h0, 0);
    xfer(0, 0, 8'h41, 32'h0, 4'h0, 0);          idle(1);
    // zero-strobe write leaves data intact
    xfer(0, 1, 8'h04, 32'hAAAA_AAAA, 4'h0, 0);
    xfer(0, 0, 8'h04, 32'h0, 4'h0, 0);          idle(1);
    // aborted write
    xfer(0, 1, 8'h0C, 32'hDEAD_BEEF, 4'hF, 0);  idle(1);
    xfer(0, 1, 8'h0C, 32'h1111_1111, 4'hF, 1);  idle(1);
    xfer(0, 0, 8'h0C, 32'h0, 4'h0, 0);          idle(1);
    // access phase without setup is ignored
    psel0 = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h0C;
    repeat (3) begin @(posedge clk); #1; end
    idle(1);
    xfer(0, 0, 8'h0C, 32'h0, 4'h0, 0);          idle(1);

    // random traffic, two wait states
    for (int n = 0; n < 60; n++) begin
      xfer(0, 1'($urandom_range(0, 1)), rand_addr(), $urandom(), 4'($urandom_range(0, 15)), 0);
      idle($urandom_range(0, 2));
    end

    // zero wait states, back-to-back
    xfer(1, 1, 8'h10, 32'h0BAD_CAFE, 4'hF, 0);
    xfer(1, 0, 8'h10, 32'h0, 4'h0, 0);
    for (int n = 0; n < 30; n++) begin
      xfer(1, 1'($urandom_range(0, 1)), rand_addr(), $urandom(), 4'($urandom_range(0, 15)), 0);
      if ($urandom_range(0, 1) == 1) idle(1);
    end
    idle(1);

    // reset pulse during WAIT of a write
    xfer(0, 1, 8'h0C, 32'h5555_5555, 4'hF, 2);  idle(1);
    xfer(0, 0, 8'h0C, 32'h0, 4'h0, 0);
    xfer(0, 0, 8'h08, 32'h0, 4'h0, 0);          idle(1);
    // reset pulse while a read response is on the bus
    xfer(0, 1, 8'h04, 32'hCAFE_F00D, 4'hF, 0);  idle(1);
    xfer(0, 0, 8'h04, 32'h0, 4'h0, 3);          idle(1);
    xfer(0, 0, 8'h04, 32'h0, 4'h0, 0);          idle(1);
    xfer(1, 0, 8'h10, 32'h0, 4'h0, 0);          idle(3);

    vectors++;
    if (q0.size() != 0 || q1.size() != 0) begin
      miscompares++;
      $display("FAIL pending_responses: got %0d/%0d outstanding, want 0/0", q0.size(), q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule
